// File: rtl/mem_sweep_bank.sv
// Register-array bank over an arbitrary LEFT:RIGHT index range with one write port,
// one registered read port and a sweep engine (fill / index / invert / check).
//
// state | meaning
// IDLE  | accepting external writes, waiting for sweep_start
// SWEEP | one word per cycle at ptr, walking LEFT toward RIGHT
module mem_sweep_bank #(
  parameter int WIDTH  = 4,
  parameter int LEFT   = 16,
  parameter int RIGHT  = 14,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              sweep_start,
  input  logic [1:0]        sweep_mode,
  input  logic [WIDTH-1:0]  sweep_data,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic [ADDR_W:0]   err_count
);

  localparam int LO    = (LEFT < RIGHT) ? LEFT : RIGHT;
  localparam int HI    = (LEFT < RIGHT) ? RIGHT : LEFT;
  localparam int DEPTH = HI - LO + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ASC   = (RIGHT >= LEFT);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t state, state_nx;
  logic [WIDTH-1:0]  mem [2**IDX_W];
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  cur_word;
  logic [WIDTH-1:0]  sweep_word;
  logic              wr_ok;
  logic              rd_ok;

  // Offset from the low bound; an address below LO wraps into the extra MSB and fails the compare.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (({1'b0, a} - (ADDR_W+1)'(LO)) <= (ADDR_W+1)'(DEPTH - 1));
  endfunction

  assign wr_ok    = in_range(wr_addr);
  assign rd_ok    = in_range(rd_addr);
  assign cur_word = mem[IDX_W'(ptr - ADDR_W'(LO))];

  always_comb begin
    sweep_word = cur_word;
    case (mode_q)
      2'd0:    sweep_word = data_q;
      2'd1:    sweep_word = WIDTH'({{WIDTH{1'b0}}, ptr});
      2'd2:    sweep_word = ~cur_word;
      default: sweep_word = cur_word;
    endcase
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) state_nx = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (ptr == ADDR_W'(RIGHT)) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      ptr       <= ADDR_W'(LEFT);
      mode_q    <= 2'd0;
      data_q    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      wr_drop   <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
    end else begin
      state   <= state_nx;
      wr_drop <= wr_en && busy;

      if (state == IDLE && sweep_start) begin
        mode_q <= sweep_mode;
        data_q <= sweep_data;
        ptr    <= ADDR_W'(LEFT);
        if (sweep_mode == 2'd3) err_count <= '0;
      end else if (state == SWEEP) begin
        if (mode_q == 2'd3) begin
          if (cur_word != data_q && err_count != '1) err_count <= err_count + 1'b1;
        end else begin
          mem[IDX_W'(ptr - ADDR_W'(LO))] <= sweep_word;
        end
        ptr <= ASC ? ptr + 1'b1 : ptr - 1'b1;
      end

      // Sweep writes only happen in SWEEP, so they never collide with this port.
      if (wr_en && !busy && wr_ok) mem[IDX_W'(wr_addr - ADDR_W'(LO))] <= wr_data;

      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_ok ? mem[IDX_W'(rd_addr - ADDR_W'(LO))] : '0;
        rd_err  <= !rd_ok;
      end else begin
        rd_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_sweep_bank.sv
// Directed bench for mem_sweep_bank: descending default instance plus an ascending 2:5 instance.
module tb_mem_sweep_bank;

  logic       clk = 1'b0;
  logic       clear, wr_en, rd_en, sweep_start;
  logic [4:0] wr_addr, rd_addr;
  logic [3:0] wr_data, sweep_data, rd_data;
  logic [1:0] sweep_mode;
  logic       rd_valid, rd_err, busy, done, wr_drop;
  logic [5:0] err_count;

  logic       a_rd_en, a_start;
  logic [2:0] a_rd_addr;
  logic [3:0] a_rd_data;
  logic       a_rd_valid, a_rd_err, a_busy, a_done, a_wr_drop;
  logic [3:0] a_err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_sweep_bank dut (
    .clock(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .sweep_start(sweep_start), .sweep_mode(sweep_mode), .sweep_data(sweep_data),
    .busy(busy), .done(done), .wr_drop(wr_drop), .err_count(err_count)
  );

  mem_sweep_bank #(.WIDTH(4), .LEFT(2), .RIGHT(5), .ADDR_W(3)) u_asc (
    .clock(clk), .clear(clear), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(4'd0),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .rd_err(a_rd_err), .sweep_start(a_start), .sweep_mode(2'd1), .sweep_data(4'd0),
    .busy(a_busy), .done(a_done), .wr_drop(a_wr_drop), .err_count(a_err_count)
  );

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [4:0] ra;
    logic       ev;
    logic [3:0] ed;
    logic       ee;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [3:0] exp, input string nm);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({nm, " valid"}, rd_valid, 1'b1);
    chk({nm, " data"}, rd_data, exp);
  endtask

  task automatic sweep(input logic [1:0] m, input logic [3:0] d, input string nm);
    int n, dn, dc;
    sweep_start = 1'b1; sweep_mode = m; sweep_data = d;
    @(negedge clk);
    sweep_start = 1'b0;
    n = 0; dn = 0; dc = 0;
    while (busy && n < 20) begin
      n++;
      if (done) begin dn++; dc = n; end
      @(negedge clk);
    end
    chk({nm, " busy len"}, n, 3);
    chk({nm, " done count"}, dn, 1);
    chk({nm, " done cycle"}, dc, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, dn, dc;
    clear = 1'b1; wr_en = 0; rd_en = 0; sweep_start = 0;
    wr_addr = 0; rd_addr = 0; wr_data = 0; sweep_data = 0; sweep_mode = 0;
    a_rd_en = 0; a_start = 0; a_rd_addr = 0;

    vt[0]  = '{1'b1, 5'd16, 4'hA, 1'b0, 5'd0,  1'b0, 4'h0, 1'b0};
    vt[1]  = '{1'b1, 5'd15, 4'h5, 1'b0, 5'd0,  1'b0, 4'h0, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd16, 1'b1, 4'hA, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd15, 1'b1, 4'h5, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd14, 1'b1, 4'h0, 1'b0};
    vt[5]  = '{1'b1, 5'd13, 4'hF, 1'b0, 5'd0,  1'b0, 4'h0, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd13, 1'b1, 4'h0, 1'b1};
    vt[7]  = '{1'b1, 5'd17, 4'h9, 1'b1, 5'd17, 1'b1, 4'h0, 1'b1};
    vt[8]  = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd16, 1'b1, 4'hA, 1'b0};
    vt[9]  = '{1'b1, 5'd14, 4'h7, 1'b1, 5'd14, 1'b1, 4'h0, 1'b0};
    vt[10] = '{1'b0, 5'd0,  4'h0, 1'b1, 5'd14, 1'b1, 4'h7, 1'b0};
    vt[11] = '{1'b0, 5'd0,  4'h0, 1'b0, 5'd14, 1'b0, 4'h7, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset rd_data", rd_data, 4'h0);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset wr_drop", wr_drop, 1'b0);
    chk("reset err_count", err_count, 6'd0);
    clear = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en = vt[i].re; rd_addr = vt[i].ra;
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), rd_valid, vt[i].ev);
      chk($sformatf("vec%0d data", i), rd_data, vt[i].ed);
      chk($sformatf("vec%0d err", i), rd_err, vt[i].ee);
    end
    wr_en = 0; rd_en = 0;

    sweep(2'd0, 4'hC, "fill");
    rd(5'd16, 4'hC, "fill r16"); rd(5'd15, 4'hC, "fill r15"); rd(5'd14, 4'hC, "fill r14");

    sweep(2'd1, 4'h0, "index");
    rd(5'd16, 4'h0, "index r16"); rd(5'd15, 4'hF, "index r15"); rd(5'd14, 4'hE, "index r14");

    sweep(2'd2, 4'h0, "invert");
    rd(5'd16, 4'hF, "invert r16"); rd(5'd15, 4'h0, "invert r15"); rd(5'd14, 4'h1, "invert r14");

    sweep(2'd0, 4'h3, "fill3");
    wr_en = 1'b1; wr_addr = 5'd15; wr_data = 4'h0;
    @(negedge clk);
    wr_en = 1'b0;
    sweep(2'd3, 4'h3, "check");
    chk("check err_count", err_count, 6'd1);

    // Read during a sweep write of the same word returns the pre-sweep value.
    sweep_start = 1'b1; sweep_mode = 2'd0; sweep_data = 4'h6;
    @(negedge clk);
    sweep_start = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd16;
    @(negedge clk);
    rd_en = 1'b0;
    chk("sweep-read old data", rd_data, 4'h3);
    repeat (3) @(negedge clk);
    chk("sweep-read idle", busy, 1'b0);
    rd(5'd16, 4'h6, "after fill6 r16");
    chk("err_count holds", err_count, 6'd1);

    // Write during a check sweep is dropped.
    sweep_start = 1'b1; sweep_mode = 2'd3; sweep_data = 4'h6;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("drop busy", busy, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd15; wr_data = 4'h9;
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_drop pulse", wr_drop, 1'b1);
    @(negedge clk);
    chk("wr_drop clears", wr_drop, 1'b0);
    chk("drop done", done, 1'b1);
    @(negedge clk);
    rd(5'd15, 4'h6, "dropped r15");
    chk("drop err_count", err_count, 6'd0);

    // Clear on sweep cycle 2 aborts without done.
    sweep_start = 1'b1; sweep_mode = 2'd0; sweep_data = 4'hC;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("abort cyc1 done", done, 1'b0);
    @(negedge clk);
    chk("abort cyc2 busy", busy, 1'b1);
    chk("abort cyc2 done", done, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    @(negedge clk);
    chk("abort idle done", done, 1'b0);
    chk("abort idle busy", busy, 1'b0);
    rd(5'd16, 4'h0, "abort r16"); rd(5'd15, 4'h0, "abort r15"); rd(5'd14, 4'h0, "abort r14");

    // Ascending instance: index sweep walks 2,3,4,5.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    n = 0; dn = 0; dc = 0;
    while (a_busy && n < 20) begin
      n++;
      if (a_done) begin dn++; dc = n; end
      @(negedge clk);
    end
    chk("asc busy len", n, 4);
    chk("asc done count", dn, 1);
    chk("asc done cycle", dc, 4);
    for (int a = 2; a <= 5; a++) begin
      a_rd_en = 1'b1; a_rd_addr = 3'(a);
      @(negedge clk);
      a_rd_en = 1'b0;
      chk($sformatf("asc r%0d", a), a_rd_data, 4'(a));
      chk($sformatf("asc r%0d valid", a), a_rd_valid, 1'b1);
    end
    a_rd_en = 1'b1; a_rd_addr = 3'd6;
    @(negedge clk);
    a_rd_en = 1'b0;
    chk("asc r6 err", a_rd_err, 1'b1);
    chk("asc r6 data", a_rd_data, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
